cdm_msgst_arb: RTL and testbench
================================

# cdm_msgst_arb

Round-robin, packet-atomic arbiter that shares the single CDM message-store (msgst) port among up to NUM_REQ fabric requesters, such as the msgst traffic generator, interrupt sources and payload replay engines. It sits between those requesters and the `cdm0_msgst_0_*` port of the CPM5N wrapper. Each granted packet is forwarded beat by beat through one registered output stage. A grant is held from the first beat until the EOP beat, so multi-beat packets are never interleaved.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- MSG_W, 476: width of the opaque msgst beat (the flattened msgst interface struct, EOP excluded).
- ID_W, $clog2(NUM_REQ): width of the requester index.

- fabric_clk  in  1  single clock for all logic.
- fabric_rst_n  in  1  asynchronous, active-low reset.
- req_vld  in  NUM_REQ  per-requester beat valid.
- req_rdy  out  NUM_REQ  per-requester beat ready; at most one bit is set in any cycle.
- req_msg  in  NUM_REQ*MSG_W  per-requester beat; requester i occupies bits [i*MSG_W +: MSG_W].
- req_eop  in  NUM_REQ  per-requester last-beat flag.
- req_mask  in  NUM_REQ  1 = requester is eligible for a new grant; quasi-static.
- msgst_vld  out  1  output beat valid.
- msgst_rdy  in  1  output beat ready from the CDM.
- msgst_msg  out  MSG_W  output beat.
- msgst_eop  out  1  output last-beat flag.
- msgst_src  out  ID_W  index of the requester that supplied the current output beat.
- pkt_cnt  out  32  count of packets delivered downstream; wraps at 2^32.
- busy  out  1  high while a packet is locked or msgst_vld is high.

## Operation
- Handshake: a beat transfers on a cycle where vld and rdy are both high. A requester holds vld, msg and eop stable until rdy. The arbiter holds msgst_vld, msgst_msg, msgst_eop and msgst_src stable until msgst_rdy.
- Output stage: one register. Define can_load = !msgst_vld || msgst_rdy.
- FSM states are IDLE and LOCKED. It also keeps lock_id (ID_W bits) and rr_ptr (ID_W bits, the highest-priority index).
- IDLE, selection:
  - Eligible requesters: req_vld & req_mask.
  - Winner: the first eligible index found scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_rdy[winner] = can_load, combinationally in the same cycle.
- IDLE, accepted beat with eop=1: the output register loads the beat and msgst_src = winner. rr_ptr becomes winner+1 modulo NUM_REQ. The FSM stays in IDLE.
- IDLE, accepted beat with eop=0: the output register loads the beat. lock_id = winner. The FSM goes to LOCKED. rr_ptr is unchanged.
- LOCKED:
  - req_rdy[lock_id] = can_load; all other req_rdy bits are 0.
  - req_mask is ignored for lock_id, so masking mid-packet never truncates a packet.
  - An accepted beat with eop=1 sets rr_ptr = lock_id+1 modulo NUM_REQ and returns the FSM to IDLE.
- pkt_cnt increments on each downstream transfer (msgst_vld && msgst_rdy) where msgst_eop = 1.
- No eligible requester in IDLE: all req_rdy bits are 0 and no state changes.

## Timing
- Reset (asynchronous assert; deassert synchronised upstream):
  - FSM = IDLE, rr_ptr = 0, lock_id = 0.
  - msgst_vld = 0, msgst_msg = 0, msgst_eop = 0, msgst_src = 0.
  - pkt_cnt = 0, busy = 0, req_rdy = 0.
- Latency: a beat accepted at cycle N appears on msgst_* at cycle N+1.
- Throughput: with msgst_rdy held high, one beat per cycle, including the beat after an EOP, which comes from the next winner with no bubble.
- Back-pressure: when msgst_rdy = 0 and msgst_vld = 1, all req_rdy bits are 0 in that same cycle.
- A new grant decision is made every cycle in IDLE. The arbiter never inserts an idle cycle between packets.
- Reset during a packet clears the lock immediately, and downstream sees a truncated packet. This is legal only because the CDM reset domain is shared.
- Boundary cases:
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - A single eligible requester is granted back to back regardless of rr_ptr.
  - pkt_cnt wraps from 0xFFFF_FFFF to 0.
- req_rdy depends combinationally on req_vld, req_mask and msgst_rdy. Requesters must not make vld depend on rdy.

## Test plan
- Reset, then all four requesters issue single-beat packets continuously with msgst_rdy=1:
  - msgst_src sequence is 0,1,2,3,0,1… with one beat per cycle.
  - pkt_cnt = 8 after 8 transfers.
- Requester 1 sends a 3-beat packet while requester 2 is valid throughout:
  - Output is 1,1,1 (EOP on the third beat), then 2.
  - req_rdy[2] stays 0 until the cycle the EOP beat of requester 1 is accepted.
- msgst_rdy toggles 1,0,0,1 during a 4-beat packet from requester 3:
  - Output beats are stable while stalled, with no duplication or loss.
  - Order and data match the input exactly.
- req_mask[0] is cleared after the first beat of a 2-beat packet from requester 0:
  - The packet completes.
  - Requester 0 is not granted again while the mask stays 0.
- fabric_rst_n is asserted mid-packet (after beat 2 of 4):
  - msgst_vld drops asynchronously and the FSM returns to IDLE.
  - After release, rr_ptr = 0 and a fresh packet from requester 0 is granted first.
- pkt_cnt is preloaded through a force to 0xFFFF_FFFE and two packets are sent: pkt_cnt reads 0x0000_0000.

Source files
------------

// File: rtl/cdm_msgst_arb.sv
// Packet-atomic round-robin arbiter that multiplexes fabric requesters onto the
// single CDM message-store port through one registered output stage.
module cdm_msgst_arb #(
    parameter int NUM_REQ = 4,
    parameter int MSG_W   = 476,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     fabric_clk,
    input  logic                     fabric_rst_n,
    input  logic [NUM_REQ-1:0]       req_vld,
    output logic [NUM_REQ-1:0]       req_rdy,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg,
    input  logic [NUM_REQ-1:0]       req_eop,
    input  logic [NUM_REQ-1:0]       req_mask,
    output logic                     msgst_vld,
    input  logic                     msgst_rdy,
    output logic [MSG_W-1:0]         msgst_msg,
    output logic                     msgst_eop,
    output logic [ID_W-1:0]          msgst_src,
    output logic [31:0]              pkt_cnt,
    output logic                     busy
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   lock_id_q, lock_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              msgst_vld_q, msgst_vld_d;
    logic [MSG_W-1:0]  msgst_msg_q, msgst_msg_d;
    logic              msgst_eop_q, msgst_eop_d;
    logic [ID_W-1:0]   msgst_src_q, msgst_src_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;

    logic              can_load;
    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   grant_nxt;
    logic              sel_vld;
    logic              sel_eop;
    logic [MSG_W-1:0]  sel_msg;
    logic              accept;

    // Scan from the highest offset down so the index closest to rr_ptr wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_b;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        idx_b  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_b = ID_W'(idx);
            if (req_vld[idx_b] && req_mask[idx_b]) begin
                found  = 1'b1;
                winner = idx_b;
            end
        end
    end

    always_comb begin
        can_load  = !msgst_vld_q || msgst_rdy;
        grant_id  = (state_q == LOCKED) ? lock_id_q : winner;
        sel_vld   = (state_q == LOCKED) ? req_vld[lock_id_q] : found;
        sel_eop   = req_eop[grant_id];
        sel_msg   = req_msg[int'(grant_id)*MSG_W +: MSG_W];
        grant_nxt = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        accept    = fabric_rst_n && can_load && sel_vld;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !sel_eop) state_d = LOCKED;
            LOCKED:  if (accept && sel_eop)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by reset so nothing is handed out while reset is asserted.
    always_comb begin
        req_rdy = '0;
        if (fabric_rst_n && can_load) begin
            if (state_q == LOCKED)
                req_rdy[lock_id_q] = 1'b1;
            else if (found)
                req_rdy[winner] = 1'b1;
        end
    end

    always_comb begin
        lock_id_d   = lock_id_q;
        rr_ptr_d    = rr_ptr_q;
        msgst_vld_d = msgst_vld_q;
        msgst_msg_d = msgst_msg_q;
        msgst_eop_d = msgst_eop_q;
        msgst_src_d = msgst_src_q;
        pkt_cnt_d   = pkt_cnt_q;
        if (can_load) msgst_vld_d = accept;
        if (accept) begin
            msgst_msg_d = sel_msg;
            msgst_eop_d = sel_eop;
            msgst_src_d = grant_id;
            if (sel_eop)
                rr_ptr_d = grant_nxt;
            else if (state_q == IDLE)
                lock_id_d = winner;
        end
        if (msgst_vld_q && msgst_rdy && msgst_eop_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end

    always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
        if (!fabric_rst_n) begin
            state_q     <= IDLE;
            lock_id_q   <= '0;
            rr_ptr_q    <= '0;
            msgst_vld_q <= 1'b0;
            msgst_msg_q <= '0;
            msgst_eop_q <= 1'b0;
            msgst_src_q <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_id_q   <= lock_id_d;
            rr_ptr_q    <= rr_ptr_d;
            msgst_vld_q <= msgst_vld_d;
            msgst_msg_q <= msgst_msg_d;
            msgst_eop_q <= msgst_eop_d;
            msgst_src_q <= msgst_src_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign msgst_vld = msgst_vld_q;
    assign msgst_msg = msgst_msg_q;
    assign msgst_eop = msgst_eop_q;
    assign msgst_src = msgst_src_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign busy      = (state_q == LOCKED) || msgst_vld_q;

endmodule

// File: tb/tb_cdm_msgst_arb.sv
// Directed bench for cdm_msgst_arb: requester beat queues feed the DUT and every
// downstream transfer is logged and compared with hand-computed sequences.
module tb_cdm_msgst_arb;
    localparam int N  = 4;
    localparam int MW = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_vld, req_rdy, req_eop, req_mask;
    logic [N*MW-1:0]   req_msg;
    logic              msgst_vld, msgst_rdy, msgst_eop;
    logic [MW-1:0]     msgst_msg;
    logic [IW-1:0]     msgst_src;
    logic [31:0]       pkt_cnt;
    logic              busy;

    always #5 clk = ~clk;

    cdm_msgst_arb #(.NUM_REQ(N), .MSG_W(MW), .ID_W(IW)) dut (
        .fabric_clk(clk), .fabric_rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_msg(req_msg),
        .req_eop(req_eop), .req_mask(req_mask),
        .msgst_vld(msgst_vld), .msgst_rdy(msgst_rdy), .msgst_msg(msgst_msg),
        .msgst_eop(msgst_eop), .msgst_src(msgst_src),
        .pkt_cnt(pkt_cnt), .busy(busy)
    );

    typedef struct packed {logic eop; logic [MW-1:0] msg;} beat_t;

    beat_t          rq[N][$];
    int             out_src[$];
    logic [MW-1:0]  out_msg[$];
    bit             out_eop[$];
    int             out_cyc[$];
    int             acc_req[$];
    int             acc_cyc[$];
    int             cyc, total, bad;
    bit             stall_prev;
    logic [MW+IW+1:0] snap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input int r, input int p, input int b);
        return {4'(r), 4'(p), 8'(b)};
    endfunction

    task automatic push(input int r, input int p, input int nb);
        for (int b = 0; b < nb; b++) rq[r].push_back({(b == nb - 1), mk(r, p, b)});
    endtask

    task automatic clear_logs();
        out_src.delete(); out_msg.delete(); out_eop.delete(); out_cyc.delete();
        acc_req.delete(); acc_cyc.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_vld[i] = 1'b1;
                req_eop[i] = rq[i][0].eop;
                req_msg[i*MW +: MW] = rq[i][0].msg;
            end else begin
                req_vld[i] = 1'b0;
                req_eop[i] = 1'b0;
                req_msg[i*MW +: MW] = '0;
            end
        end
    endtask

    // One clock: drive at negedge, sample just after, pop accepted beats at posedge.
    task automatic cycle();
        logic [N-1:0] take;
        drive();
        #1;
        chk("rdy_onehot", 64'($countones(req_rdy) <= 1), 64'd1);
        if (msgst_vld && !msgst_rdy) chk("bp_rdy", 64'(req_rdy), 64'd0);
        if (stall_prev) chk("stall_hold", 64'({msgst_vld, msgst_eop, msgst_src, msgst_msg}), 64'(snap));
        stall_prev = msgst_vld && !msgst_rdy;
        snap = {msgst_vld, msgst_eop, msgst_src, msgst_msg};
        if (msgst_vld && msgst_rdy) begin
            out_src.push_back(int'(msgst_src));
            out_msg.push_back(msgst_msg);
            out_eop.push_back(msgst_eop);
            out_cyc.push_back(cyc);
        end
        take = req_vld & req_rdy;
        for (int i = 0; i < N; i++)
            if (take[i]) begin
                acc_req.push_back(i);
                acc_cyc.push_back(cyc);
            end
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (take[i]) void'(rq[i].pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int b = 0;
        while (out_src.size() < n && b < budget) begin
            cycle();
            b++;
        end
        chk(tag, 64'(out_src.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int e_src[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int pat[10]  = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        total = 0; bad = 0; cyc = 0; stall_prev = 0; snap = '0;
        rst_n = 1'b0; msgst_rdy = 1'b1; req_mask = '1;
        req_vld = '0; req_eop = '0; req_msg = '0;

        // Reset state, with a requester valid to prove ready stays low.
        repeat (2) @(negedge clk);
        req_vld = 4'b0001;
        #1;
        chk("rst_vld", 64'(msgst_vld), 64'd0);
        chk("rst_msg", 64'(msgst_msg), 64'd0);
        chk("rst_eop", 64'(msgst_eop), 64'd0);
        chk("rst_src", 64'(msgst_src), 64'd0);
        chk("rst_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdy", 64'(req_rdy), 64'd0);
        req_vld = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin over four single-beat requesters, rr_ptr wrap 3 -> 0.
        clear_logs();
        for (int r = 0; r < N; r++) begin push(r, 0, 1); push(r, 1, 1); end
        run_until("rr_n", 8, 40);
        for (int k = 0; k < 8; k++) begin
            chk("rr_src", 64'(out_src[k]), 64'(e_src[k]));
            chk("rr_msg", 64'(out_msg[k]), 64'(mk(e_src[k], k / 4, 0)));
            chk("rr_gap", 64'(out_cyc[k] - out_cyc[0]), 64'(k));
        end
        chk("rr_lat", 64'(out_cyc[0]), 64'(acc_cyc[0] + 1));
        chk("rr_cnt", 64'(pkt_cnt), 64'd8);
        chk("rr_busy", 64'(busy), 64'd0);

        // Three-beat packet from 1 holds off requester 2 until its EOP.
        clear_logs();
        push(1, 0, 3); push(2, 0, 1);
        run_until("lk_n", 4, 40);
        chk("lk_s0", 64'(out_src[0]), 64'd1);
        chk("lk_s1", 64'(out_src[1]), 64'd1);
        chk("lk_s2", 64'(out_src[2]), 64'd1);
        chk("lk_s3", 64'(out_src[3]), 64'd2);
        chk("lk_e", 64'({out_eop[0], out_eop[1], out_eop[2], out_eop[3]}), 64'b0011);
        chk("lk_m2", 64'(out_msg[2]), 64'(mk(1, 0, 2)));
        chk("lk_acc", 64'(acc_req[3]), 64'd2);
        chk("lk_acc_cyc", 64'(acc_cyc[3]), 64'(acc_cyc[2] + 1));
        chk("lk_gap", 64'(out_cyc[3] - out_cyc[0]), 64'd3);

        // Four-beat packet from 3 under downstream stalls.
        clear_logs();
        push(3, 0, 4);
        for (int i = 0; i < 10; i++) begin
            msgst_rdy = pat[i][0];
            cycle();
        end
        msgst_rdy = 1'b1;
        chk("st_n", 64'(out_src.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("st_src", 64'(out_src[k]), 64'd3);
            chk("st_msg", 64'(out_msg[k]), 64'(mk(3, 0, k)));
            chk("st_eop", 64'(out_eop[k]), 64'(k == 3));
        end

        // Mask cleared mid-packet: packet completes, then requester 0 is skipped.
        clear_logs();
        push(0, 0, 2); push(0, 1, 1); push(1, 0, 1);
        cycle();
        req_mask[0] = 1'b0;
        repeat (8) cycle();
        chk("mk_n", 64'(out_src.size()), 64'd3);
        chk("mk_s", 64'({out_src[0][1:0], out_src[1][1:0], out_src[2][1:0]}), 64'b00_00_01);
        chk("mk_e1", 64'(out_eop[1]), 64'd1);
        chk("mk_pend", 64'(rq[0].size()), 64'd1);
        req_mask[0] = 1'b1;
        run_until("mk_n2", 4, 20);
        chk("mk_s3", 64'(out_src[3]), 64'd0);
        chk("mk_m3", 64'(out_msg[3]), 64'(mk(0, 1, 0)));

        // Single eligible requester is granted back to back.
        clear_logs();
        push(2, 0, 1); push(2, 1, 1); push(2, 2, 1);
        run_until("se_n", 3, 20);
        for (int k = 0; k < 3; k++) begin
            chk("se_src", 64'(out_src[k]), 64'd2);
            chk("se_gap", 64'(out_cyc[k] - out_cyc[0]), 64'(k));
        end

        // Reset asserted after two beats of a four-beat packet.
        clear_logs();
        push(1, 0, 4);
        b = 0;
        while (acc_req.size() < 2 && b < 20) begin
            cycle();
            b++;
        end
        chk("ra_acc", 64'(acc_req.size()), 64'd2);
        chk("ra_busy_pre", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_vld", 64'(msgst_vld), 64'd0);
        chk("ra_busy", 64'(busy), 64'd0);
        chk("ra_rdy", 64'(req_rdy), 64'd0);
        chk("ra_cnt", 64'(pkt_cnt), 64'd0);
        rq[1].delete();
        stall_prev = 0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        push(3, 1, 1); push(0, 1, 1);
        run_until("ra_n", 2, 20);
        chk("ra_s0", 64'(out_src[0]), 64'd0);
        chk("ra_s1", 64'(out_src[1]), 64'd3);
        chk("ra_cnt2", 64'(pkt_cnt), 64'd2);

        // Counter wrap from a preloaded 0xFFFF_FFFE.
        force dut.pkt_cnt_q = 32'hFFFF_FFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.pkt_cnt_q;
        #1;
        chk("wr_pre", 64'(pkt_cnt), 64'hFFFF_FFFE);
        clear_logs();
        push(0, 2, 1); push(1, 2, 1);
        run_until("wr_n", 2, 20);
        chk("wr_cnt", 64'(pkt_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
